// File: rtl/aes128_rr_scheduler_if.sv
// Request/response bundle between client blocks and the shared AES-128 scheduler.
// Requester i occupies bit i of req_valid/req_ready and bits [128*i +: 128] of
// req_state/req_key.
interface aes128_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
);
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*128-1:0] req_state;
    logic [NUM_REQ*128-1:0] req_key;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [127:0]           rsp_data;
    logic [IDW-1:0]         rsp_id;
    logic                   rsp_err;

    // Client side: issues requests, consumes responses
    modport master (
        output req_valid, req_state, req_key, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );

    // Scheduler side: accepts requests, produces responses
    modport slave (
        input  req_valid, req_state, req_key, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
endinterface

// File: rtl/aes128_rr_scheduler.sv
// Round-robin front end for a single shared aes_128 core. One job is in flight
// at a time: grant, load operands, pulse start, wait for out_valid (or the
// watchdog), then hold the response until the consumer takes it.
module aes128_rr_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int IDW            = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    aes128_rr_scheduler_if.slave bus,
    output logic                 core_start,
    output logic [127:0]         core_state,
    output logic [127:0]         core_key,
    input  logic [127:0]         core_out,
    input  logic                 core_out_valid,
    output logic                 busy
);
    localparam int WDW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     id;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic               grant_found;
    logic [NUM_REQ-1:0] ready_vec;
    logic [127:0]       sel_state;
    logic [127:0]       sel_key;
    logic [WDW-1:0]     wd;
    logic               rsp_valid_r;
    logic [127:0]       rsp_data_r;
    logic               rsp_err_r;

    // Round-robin search: first valid requester strictly after the last winner
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Accept strobe goes only to the winner and only while idle
    always_comb begin
        ready_vec = '0;
        if (state == IDLE && grant_found) begin
            ready_vec[grant_idx] = 1'b1;
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_state = '0;
        sel_key   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_state = bus.req_state[128*i +: 128];
                sel_key   = bus.req_key[128*i +: 128];
            end
        end
    end

    assign bus.req_ready = ready_vec;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_id    = id;
    assign bus.rsp_err   = rsp_err_r;

    // Job sequencer; every output except req_ready is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= IDW'(NUM_REQ - 1);
            id          <= '0;
            wd          <= '0;
            core_start  <= 1'b0;
            core_state  <= '0;
            core_key    <= '0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
            rsp_err_r   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        core_state <= sel_state;
                        core_key   <= sel_key;
                        id         <= grant_idx;
                        ptr        <= grant_idx;
                        busy       <= 1'b1;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    // Operands have been stable at the core for a full cycle
                    core_start <= 1'b1;
                    state      <= START;
                end
                START: begin
                    // core_out_valid is deliberately not looked at here
                    core_start <= 1'b0;
                    wd         <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_out_valid) begin
                        rsp_data_r  <= core_out;
                        rsp_err_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        state       <= RESP;
                    end else if (wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                        rsp_data_r  <= '0;
                        rsp_err_r   <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    core_start  <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
